// File: rtl/stopwatch_scan_display_pkg.sv
// stopwatch_pkg: shared state type, BCD digit type and 7-segment decode for the stopwatch
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    typedef logic [3:0] bcd_t;
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    function automatic bcd_t digit_max(input int i);
        return i == 3 ? 4'd5 : 4'd9;
    endfunction
    function automatic logic [7:0] seg_decode(input bcd_t d, input logic dp);
        logic [7:0] s;
        s = d <= 4'd9 ? SEG_DIGIT[d] : SEG_BLANK;
        return dp ? (s & 8'h7F) : s;
    endfunction
endpackage

// File: rtl/stopwatch_scan_display_if.sv
// stopwatch_scan_display_if: divider/button inputs and segment/anode drive of the stopwatch
interface stopwatch_scan_display_if;
    logic       clk_10000Hz;
    logic       clk_250Hz;
    logic       start_stop;
    logic       clear;
    logic [7:0] seg;
    logic [3:0] an;
    modport master (output clk_10000Hz, clk_250Hz, start_stop, clear, input seg, an);
    modport slave (input clk_10000Hz, clk_250Hz, start_stop, clear, output seg, an);
endinterface

// File: rtl/stopwatch_scan_display_sync.sv
// sync_rise_detect: 2-FF synchronizer plus edge register giving a one-cycle pulse per rising edge
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic s0, s1, prev;
    always_ff @(posedge clk or posedge rst)
        if (rst) {s0, s1, prev} <= '0;
        else {s0, s1, prev} <= {d, s0, s1};
    assign pulse = s1 & ~prev;
endmodule

// File: rtl/stopwatch_scan_display.sv
// stopwatch_scan_display: 00.00-59.99 stopwatch with multiplexed 7-segment scan drive
module stopwatch_scan_display
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS   = 100,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input logic BoardCLK,
    input logic Reset,
    stopwatch_scan_display_if.slave io
);
    localparam logic [7:0] INV = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;
    logic          tick_cs_raw, tick_scan, tick_ss, cs_inc;
    state_t        state;
    logic [6:0]    presc;
    bcd_t [3:0]    digits, nd;
    logic [3:0]    carry;
    logic [1:0]    idx;
    logic [3:0]    an_n;
    logic [7:0]    seg_n;
    sync_rise_detect u_cs (.clk(BoardCLK), .rst(Reset), .d(io.clk_10000Hz), .pulse(tick_cs_raw));
    sync_rise_detect u_scan (.clk(BoardCLK), .rst(Reset), .d(io.clk_250Hz), .pulse(tick_scan));
    sync_rise_detect u_ss (.clk(BoardCLK), .rst(Reset), .d(io.start_stop), .pulse(tick_ss));
    assign cs_inc = state == RUN && tick_cs_raw && presc == 7'(TICKS_PER_CS - 1);
    // Ripple BCD carry; d3 wraps at 5 so 59.99 rolls over to 00.00
    always_comb begin
        carry[0] = cs_inc;
        for (int i = 1; i < 4; i++)
            carry[i] = carry[i-1] && digits[i-1] >= digit_max(i - 1);
        nd = digits;
        for (int i = 0; i < 4; i++)
            nd[i] = carry[i] ? (digits[i] >= digit_max(i) ? 4'd0 : digits[i] + 4'd1) : digits[i];
    end
    always_ff @(posedge BoardCLK or posedge Reset)
        if (Reset) begin
            state  <= IDLE;
            presc  <= '0;
            digits <= '0;
        end else if (io.clear) begin
            state  <= IDLE;
            presc  <= '0;
            digits <= '0;
        end else begin
            state  <= tick_ss ? (state == RUN ? PAUSE : RUN) : state;
            presc  <= state == IDLE ? '0 :
                      (state == RUN && tick_cs_raw) ? (cs_inc ? '0 : presc + 7'd1) : presc;
            digits <= state == IDLE ? '0 : nd;
        end
    always_ff @(posedge BoardCLK or posedge Reset)
        if (Reset) idx <= '0;
        else idx <= idx + {1'b0, tick_scan};
    always_comb begin
        an_n  = ~(4'b0001 << idx) ^ INV[3:0];
        seg_n = seg_decode(digits[idx], idx == 2'd2) ^ INV;
    end
    always_ff @(posedge BoardCLK or posedge Reset)
        if (Reset) begin
            io.an  <= 4'hF ^ INV[3:0];
            io.seg <= SEG_BLANK ^ INV;
        end else begin
            io.an  <= an_n;
            io.seg <= seg_n;
        end
endmodule

// File: tb/tb_stopwatch_scan_display.sv
// tb_stopwatch_scan_display: scoreboard bench for a TICKS_PER_CS=100 and a TICKS_PER_CS=1 instance
module tb_stopwatch_scan_display;
    typedef struct {
        logic [3:0] an_s;
        logic [7:0] seg_s;
        logic [3:0] an_f;
        logic [7:0] seg_f;
    } exp_t;
    typedef struct {
        bit         pulse;
        logic [3:0] an;
        logic [7:0] seg;
    } vec_t;
    localparam logic [7:0] PAT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    logic clk = 0, rst = 1, c10k = 0, c250 = 0, ss = 0, clr = 0;
    logic [1:0] idx = 0;
    int checks = 0, errors = 0;
    exp_t sbq[$];
    vec_t tv[5];
    stopwatch_scan_display_if sa ();
    stopwatch_scan_display_if sf ();
    assign sa.clk_10000Hz = c10k;
    assign sa.clk_250Hz   = c250;
    assign sa.start_stop  = ss;
    assign sa.clear       = clr;
    assign sf.clk_10000Hz = c10k;
    assign sf.clk_250Hz   = c250;
    assign sf.start_stop  = ss;
    assign sf.clear       = clr;
    stopwatch_scan_display #(.TICKS_PER_CS(100), .SEG_ACTIVE_LOW(1)) u_slow (.BoardCLK(clk), .Reset(rst), .io(sa));
    stopwatch_scan_display #(.TICKS_PER_CS(1), .SEG_ACTIVE_LOW(1)) u_fast (.BoardCLK(clk), .Reset(rst), .io(sf));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got an/seg=%h required %h", name, act, exp);
        end
    endtask

    task automatic scan_pulse(input string name, input exp_t e);
        exp_t g;
        @(negedge clk);
        c250 = 1;
        sbq.push_back(e);
        idx = idx + 2'd1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        g = sbq.pop_front();
        chk({name, " slow"}, {sa.an, sa.seg}, {g.an_s, g.seg_s});
        chk({name, " fast"}, {sf.an, sf.seg}, {g.an_f, g.seg_f});
        c250 = 0;
        repeat (3) @(posedge clk);
    endtask

    function automatic logic [7:0] seg_of(input logic [15:0] v, input logic [1:0] n);
        logic [3:0] d;
        d = v[4*n +: 4];
        return (d <= 4'd9 ? PAT[d] : 8'hFF) & (n == 2'd2 ? 8'h7F : 8'hFF);
    endfunction

    task automatic read_disp(input string name, input logic [15:0] es, input logic [15:0] ef);
        exp_t e;
        logic [1:0] n;
        for (int k = 0; k < 4; k++) begin
            n = idx + 2'd1;
            e.an_s  = ~(4'b0001 << n);
            e.seg_s = seg_of(es, n);
            e.an_f  = e.an_s;
            e.seg_f = seg_of(ef, n);
            scan_pulse(name, e);
        end
    endtask

    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c10k = 1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            c10k = 0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic ss_pulse();
        @(negedge clk);
        ss = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        ss = 0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        idx = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        tv[0] = '{0, 4'b1110, 8'hC0};
        tv[1] = '{1, 4'b1101, 8'hC0};
        tv[2] = '{1, 4'b1011, 8'h40};
        tv[3] = '{1, 4'b0111, 8'hC0};
        tv[4] = '{1, 4'b1110, 8'hC0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in reset slow", {sa.an, sa.seg}, {4'b1111, 8'hFF});
        chk("in reset fast", {sf.an, sf.seg}, {4'b1111, 8'hFF});
        rst = 0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            if (tv[i].pulse) scan_pulse($sformatf("scan vec %0d", i), '{tv[i].an, tv[i].seg, tv[i].an, tv[i].seg});
            else begin
                chk("release slow", {sa.an, sa.seg}, {tv[i].an, tv[i].seg});
                chk("release fast", {sf.an, sf.seg}, {tv[i].an, tv[i].seg});
            end
        // a clk_250Hz rise must reach an on the 4th BoardCLK edge, not earlier
        @(negedge clk);
        c250 = 1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("latency edge %0d", k), {sa.an, sa.seg}, k < 4 ? {4'b1110, 8'hC0} : {4'b1101, 8'hC0});
        end
        idx = 2'd1;
        c250 = 0;
        repeat (3) @(posedge clk);
        ss_pulse();
        edges(100);
        read_disp("run 100", 16'h0001, 16'h0100);
        do_reset();
        ss_pulse();
        edges(150);
        ss_pulse();
        edges(50);
        ss_pulse();
        edges(50);
        read_disp("pause resume", 16'h0002, 16'h0200);
        do_reset();
        ss_pulse();
        edges(5999);
        read_disp("pre wrap", 16'h0059, 16'h5999);
        edges(1);
        read_disp("wrap", 16'h0060, 16'h0000);
        @(negedge clk);
        clr = 1;
        ss = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        clr = 0;
        ss = 0;
        repeat (4) @(posedge clk);
        edges(100);
        read_disp("clear beats start", 16'h0000, 16'h0000);
        do_reset();
        ss_pulse();
        edges(3);
        @(negedge clk);
        c10k = 1;
        ss = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        c10k = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ss = 0;
        repeat (4) @(posedge clk);
        edges(10);
        read_disp("inc then pause", 16'h0000, 16'h0004);
        ss_pulse();
        edges(96);
        read_disp("resume partial", 16'h0001, 16'h0100);
        do_reset();
        ss_pulse();
        edges(1234);
        read_disp("at 12.34", 16'h0012, 16'h1234);
        @(negedge clk);
        rst = 1;
        #1;
        chk("async reset slow", {sa.an, sa.seg}, {4'b1111, 8'hFF});
        chk("async reset fast", {sf.an, sf.seg}, {4'b1111, 8'hFF});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        idx = 0;
        @(posedge clk);
        @(negedge clk);
        chk("post reset fast", {sf.an, sf.seg}, {4'b1110, 8'hC0});
        edges(20);
        read_disp("idle after reset", 16'h0000, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_scan_display.md
Name: stopwatch_scan_display

Overview:
- Four-digit 00.00–59.99 stopwatch with multiplexed common-anode 7-segment drive. Sits directly downstream of the board clock divider.
- Consumes the divider's clk_10000Hz as its timebase and clk_250Hz as its digit-scan rate. Both are sampled as data in the BoardCLK domain; they are never used as clocks.
- Drives the board's segment and anode pins.

Parameters:
- TICKS_PER_CS, 100, clk_10000Hz rising edges per 0.01 s count.
- SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 inverts both.

Ports:
- BoardCLK  in  1  single system clock; every flop in the block is clocked by it.
- Reset  in  1  asynchronous, active-high reset.
- clk_10000Hz  in  1  divider output, timebase; asynchronous level.
- clk_250Hz  in  1  divider output, scan rate; asynchronous level.
- start_stop  in  1  debounced button level; each rising edge toggles run/pause.
- clear  in  1  level; while high, counters are held at zero and state is IDLE.
- seg  out  8  {dp,g,f,e,d,c,b,a}.
- an  out  4  digit enables; an[0] = rightmost digit (0.01 s).

Behaviour:
- Input conditioning:
  - clk_10000Hz, clk_250Hz and start_stop each pass through a 2-FF synchronizer, then a registered rising-edge detector.
  - Each produces a one-BoardCLK-cycle tick: tick_cs_raw, tick_scan, tick_ss.
  - Latency from input edge to tick is 3 BoardCLK cycles.
- State machine: IDLE, RUN, PAUSE.
  - IDLE: tick_ss -> RUN.
  - RUN: tick_ss -> PAUSE.
  - PAUSE: tick_ss -> RUN.
  - clear high in any state -> IDLE next cycle. clear beats tick_ss in the same cycle.
- Prescaler (7 bits):
  - Counts tick_cs_raw only in RUN.
  - When a tick arrives with prescaler = TICKS_PER_CS-1: prescaler -> 0 and a cs_inc pulse is issued.
  - Holds its value in PAUSE, so resume continues the partial count.
  - Zeroed in IDLE.
- BCD counter, four 4-bit digits d3 d2 . d1 d0 (d3 range 0–5, others 0–9):
  - cs_inc increments d0, carrying d0 9->0 into d1, d1 9->0 into d2, d2 9->0 into d3.
  - 59.99 + cs_inc -> 00.00 (wrap; no overflow flag).
  - Digits hold in PAUSE and are zeroed in IDLE.
  - Digits never take a non-BCD value.
- Scan:
  - 2-bit index advances on each tick_scan in every state, wrapping 3->0.
  - The display stays lit in IDLE, showing 00.00.
- Outputs (registered, one cycle after index/digit change):
  - an: one-hot active on the current index.
  - seg: decode of the digit at that index.
  - dp lit only when index = 2, giving "SS.cc".
- Decode, active-low segment patterns:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - dp clears bit7 when lit.
- Reset values:
  - state IDLE; prescaler 0; digits 0; index 0; all synchronizer and edge-detect flops 0.
  - an = 4'b1111 and seg = 8'hFF (all off). These become an = 1110, seg = C0 on the first cycle after Reset deasserts.
  - Reset asserted mid-run zeroes everything immediately (asynchronously).
- Simultaneous events:
  - tick_ss and cs_inc in the same cycle in RUN: the increment is applied, then state -> PAUSE.
  - clear and cs_inc in the same cycle: clear wins and the digits become 0.

Decomposition:
- Shared package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE};
  - bcd_t (4-bit);
  - SEG_DIGIT[0:9] constant table;
  - SEG_BLANK = 8'hFF.
- Sub-module sync_rise_detect (2-FF synchronizer plus edge register, one-cycle pulse out), instantiated 3×.
- Segment decode is a function in the package, not a module.

Test Plan:
- Reset release, no stimulus, 4 scan edges -> an cycles 1110, 1101, 1011, 0111. seg = C0, C0, 40, C0 (dp lit at index 2).
- start_stop pulse, then 100 clk_10000Hz edges -> d0 = 1. Continue to 6000 cs_inc total -> display wraps 59.99 -> 00.00.
- RUN, pause after 150 raw ticks, 50 edges during PAUSE, resume, 50 more edges -> digits = 00.02 (prescaler held at 50 across the pause).
- clear and start_stop rising in the same cycle during RUN -> state IDLE, digits 00.00, prescaler 0, and no RUN entry.
- Assert Reset mid-count at 12.34 -> an = 1111, seg = FF within the same cycle. After release, displays 00.00 in IDLE.
- Input edge to tick latency: a clk_250Hz rise must change an exactly 4 BoardCLK cycles later (3 sync/detect + 1 output register).
